motor_drive_ctrl: RTL and testbench

MOTOR_DRIVE_CTRL -- requirements
Module: motor_drive_ctrl

---
 rtl/motor_drive_ctrl_if.sv | 21 ++
 rtl/motor_drive_ctrl.sv | 174 +++++++++++++++++
 tb/tb_motor_drive_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/motor_drive_ctrl_if.sv
// Command/status bundle between the star state machine and the motor drive controller.
interface motor_drive_ctrl_if;
  logic [3:0] i_cmd;
  logic       i_fault_clr;
  logic       o_grill_open;
  logic       o_grill_close;
  logic       o_star_hide;
  logic       o_star_extend;
  logic [1:0] o_busy;
  logic [1:0] o_fault;

  modport master (
    output i_cmd, i_fault_clr,
    input  o_grill_open, o_grill_close, o_star_hide, o_star_extend, o_busy, o_fault
  );

  modport slave (
    input  i_cmd, i_fault_clr,
    output o_grill_open, o_grill_close, o_star_hide, o_star_extend, o_busy, o_fault
  );
endinterface

// File: rtl/motor_drive_ctrl.sv
// Dead-time interlocked drive for the grill and star motors (index 1 = grill, 0 = star).
// Optional run watchdog with FAULT state is enabled by defining MOTOR_WATCHDOG_EN.
module motor_drive_ctrl #(
  parameter int unsigned DEAD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic               i_clk,
  input logic               i_rst_n,
  motor_drive_ctrl_if.slave bus
);

  localparam int unsigned DeadW = $clog2(DEAD_CYCLES + 1);
  localparam logic [DeadW-1:0] DeadLast = DeadW'(DEAD_CYCLES - 1);

`ifdef MOTOR_WATCHDOG_EN
  localparam int unsigned RunW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RunW-1:0] RunLast = RunW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StDead, StRunFwd, StRunRev, StFault} state_e;
`else
  typedef enum logic [2:0] {StIdle, StDead, StRunFwd, StRunRev} state_e;
`endif

  typedef enum logic [1:0] {ReqStop, ReqFwd, ReqRev} req_e;

  function automatic req_e decode(input logic [1:0] c);
    case (c)
      2'b10:   return ReqFwd;
      2'b01:   return ReqRev;
      default: return ReqStop;
    endcase
  endfunction

  logic [3:0]       cmd_q;
  state_e           state_q    [2];
  state_e           state_d    [2];
  req_e             dir_q      [2];
  req_e             dir_d      [2];
  logic [DeadW-1:0] dead_cnt_q [2];
  logic [DeadW-1:0] dead_cnt_d [2];
  logic [1:0]       fwd_d, rev_d, busy_d, fault_d;
  logic [1:0]       fwd_q, rev_q, busy_q, fault_q;

`ifdef MOTOR_WATCHDOG_EN
  logic            fault_clr_q;
  logic [RunW-1:0] run_cnt_q [2];
  logic [RunW-1:0] run_cnt_d [2];
`else
  logic unused_fault_clr;
  assign unused_fault_clr = bus.i_fault_clr;
`endif

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    dead_cnt_d = dead_cnt_q;
`ifdef MOTOR_WATCHDOG_EN
    run_cnt_d  = run_cnt_q;
`endif
    for (int i = 0; i < 2; i++) begin
      unique case (state_q[i])
        StIdle: begin
          if (decode(cmd_q[2*i +: 2]) != ReqStop) begin
            state_d[i]    = StDead;
            dir_d[i]      = decode(cmd_q[2*i +: 2]);
            dead_cnt_d[i] = '0;
          end
        end
        StDead: begin
          if (dead_cnt_q[i] >= DeadLast) begin
            dead_cnt_d[i] = '0;
            if (decode(cmd_q[2*i +: 2]) == ReqStop) begin
              state_d[i] = StIdle;
            end else if (decode(cmd_q[2*i +: 2]) == dir_q[i]) begin
              state_d[i] = (dir_q[i] == ReqFwd) ? StRunFwd : StRunRev;
`ifdef MOTOR_WATCHDOG_EN
              run_cnt_d[i] = '0;
`endif
            end else begin
              // Request changed during dead time: serve the new direction after a fresh dead time
              dir_d[i] = decode(cmd_q[2*i +: 2]);
            end
          end else begin
            dead_cnt_d[i] = dead_cnt_q[i] + DeadW'(1);
          end
        end
        StRunFwd, StRunRev: begin
          if (decode(cmd_q[2*i +: 2]) != dir_q[i]) begin
            state_d[i]    = StDead;
            dir_d[i]      = decode(cmd_q[2*i +: 2]);
            dead_cnt_d[i] = '0;
`ifdef MOTOR_WATCHDOG_EN
          end else if (run_cnt_q[i] >= RunLast) begin
            state_d[i] = StFault;
          end else begin
            run_cnt_d[i] = run_cnt_q[i] + RunW'(1);
`endif
          end
        end
`ifdef MOTOR_WATCHDOG_EN
        StFault: begin
          // ReqStop as latched direction forces the dead time to end in IDLE
          if (fault_clr_q && (cmd_q[2*i +: 2] == 2'b00)) begin
            state_d[i]    = StDead;
            dir_d[i]      = ReqStop;
            dead_cnt_d[i] = '0;
          end
        end
`endif
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_comb begin
    fwd_d   = '0;
    rev_d   = '0;
    busy_d  = '0;
    fault_d = '0;
    for (int i = 0; i < 2; i++) begin
      fwd_d[i]  = (state_d[i] == StRunFwd);
      rev_d[i]  = (state_d[i] == StRunRev);
      busy_d[i] = (state_d[i] != StIdle);
`ifdef MOTOR_WATCHDOG_EN
      fault_d[i] = (state_d[i] == StFault);
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_q      <= '0;
      state_q    <= '{StIdle, StIdle};
      dir_q      <= '{ReqStop, ReqStop};
      dead_cnt_q <= '{'0, '0};
      fwd_q      <= '0;
      rev_q      <= '0;
      busy_q     <= '0;
      fault_q    <= '0;
    end else begin
      cmd_q      <= bus.i_cmd;
      state_q    <= state_d;
      dir_q      <= dir_d;
      dead_cnt_q <= dead_cnt_d;
      fwd_q      <= fwd_d;
      rev_q      <= rev_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

`ifdef MOTOR_WATCHDOG_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fault_clr_q <= 1'b0;
      run_cnt_q   <= '{'0, '0};
    end else begin
      fault_clr_q <= bus.i_fault_clr;
      run_cnt_q   <= run_cnt_d;
    end
  end

  assign bus.o_fault = fault_q;
`else
  assign bus.o_fault = 2'b00;
`endif

  assign bus.o_grill_open  = fwd_q[1];
  assign bus.o_grill_close = rev_q[1];
  assign bus.o_star_hide   = fwd_q[0];
  assign bus.o_star_extend = rev_q[0];
  assign bus.o_busy        = busy_q;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Directed bench for motor_drive_ctrl with DEAD_CYCLES=4, TIMEOUT_CYCLES=20.
// Observed vector: {busy[1:0], fault[1:0], grill_open, grill_close, star_hide, star_extend}.
module tb_motor_drive_ctrl;

  logic clk = 1'b0;
  logic run_clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  motor_drive_ctrl_if bus ();

  motor_drive_ctrl #(
    .DEAD_CYCLES   (4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = run_clk ? ~clk : clk;

  logic [7:0] obs;
  assign obs = {bus.o_busy, bus.o_fault, bus.o_grill_open, bus.o_grill_close,
                bus.o_star_hide, bus.o_star_extend};

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Interlock: opposite drives never together nor in back-to-back cycles
  logic [3:0] prev_drv = '0;
  logic [3:0] drv;
  logic       bad_lock;
  assign drv = obs[3:0];
  assign bad_lock = (drv[3] && (drv[2] || prev_drv[2])) || (drv[2] && prev_drv[3]) ||
                    (drv[1] && (drv[0] || prev_drv[0])) || (drv[0] && prev_drv[1]);

  always @(negedge clk) begin
    if (rst_n && run_clk) begin
      vectors++;
      assert (bad_lock === 1'b0) else begin
        miscompares++;
        $error("FAIL interlock: observed drv %b prev %b expected no overlap", drv, prev_drv);
      end
    end
    prev_drv = drv;
  end

  initial begin
    rst_n           = 1'b0;
    bus.i_cmd       = 4'b0000;
    bus.i_fault_clr = 1'b0;
    #7;
    check("reset_noclk", 8'h00);
    run_clk = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("idle_after_reset", 8'h00);

    // Grill open start
    bus.i_cmd = 4'b1000;
    tick(1); check("start_e0", 8'h00);
    tick(1); check("start_busy_e1", 8'h80);
    tick(3); check("start_dead_e4", 8'h80);
    tick(1); check("start_run_e5", 8'h88);

    // Reversal to close
    bus.i_cmd = 4'b0100;
    tick(1); check("rev_e0", 8'h88);
    tick(1); check("rev_off_e1", 8'h80);
    tick(3); check("rev_dead_e4", 8'h80);
    tick(1); check("rev_run_e5", 8'h84);

    // Stop
    bus.i_cmd = 4'b0000;
    tick(1); check("stop_e0", 8'h84);
    tick(1); check("stop_off_e1", 8'h80);
    tick(4); check("stop_idle_e5", 8'h00);

    // Illegal 11 request is a STOP
    bus.i_cmd = 4'b1100;
    tick(10); check("illegal_grill", 8'h00);
    bus.i_cmd = 4'b0011;
    tick(10); check("illegal_star", 8'h00);

    // Concurrent grill open + star extend
    bus.i_cmd = 4'b1001;
    tick(5); check("both_dead_e4", 8'hC0);
    tick(1); check("both_run_e5", 8'hC9);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1 check("rst_async_cut", 8'h00);
    tick(1); check("rst_held", 8'h00);
    bus.i_cmd = 4'b1010;
    rst_n = 1'b1;
    tick(1); check("rst_rel_e0", 8'h00);
    tick(4); check("rst_rel_e4", 8'hC0);
    tick(1); check("rst_rel_e5", 8'hCA);
    bus.i_cmd = 4'b0000;
    tick(1); check("rst_stop_e0", 8'hCA);
    tick(5); check("rst_stop_e5", 8'h00);

    // Reversal during dead time restarts the dead time
    bus.i_cmd = 4'b0001;
    tick(2);
    bus.i_cmd = 4'b0010;
    tick(7); check("dead_restart_e8", 8'h40);
    tick(1); check("dead_restart_e9", 8'h42);
    bus.i_cmd = 4'b0000;
    tick(6); check("dead_restart_stop", 8'h00);

`ifdef MOTOR_WATCHDOG_EN
    // Star hide times out after 20 run cycles
    bus.i_cmd = 4'b0010;
    tick(5); check("wd_dead_e4", 8'h40);
    tick(1); check("wd_run_e5", 8'h42);
    tick(19); check("wd_run_e24", 8'h42);
    tick(1); check("wd_fault_e25", 8'h50);
    bus.i_fault_clr = 1'b1;
    tick(1);
    bus.i_fault_clr = 1'b0;
    tick(3); check("wd_clr_ignored", 8'h50);
    bus.i_cmd       = 4'b0000;
    bus.i_fault_clr = 1'b1;
    tick(1); check("wd_clr_e0", 8'h50);
    bus.i_fault_clr = 1'b0;
    tick(1); check("wd_clr_e1", 8'h40);
    tick(3); check("wd_clr_e4", 8'h40);
    tick(1); check("wd_clr_idle_e5", 8'h00);
`else
    // Without the watchdog a long run never faults
    bus.i_cmd = 4'b0010;
    tick(6); check("nowd_run_e5", 8'h42);
    bus.i_fault_clr = 1'b1;
    tick(1);
    bus.i_fault_clr = 1'b0;
    tick(24); check("nowd_long_run", 8'h42);
    bus.i_cmd = 4'b0000;
    tick(6); check("nowd_stop", 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
